// File: rtl/mem_byte_feeder_if.sv
// Handshake and host-side bus for the byte feeder: RAM write port,
// playback control, and the valid/ready byte stream to the serializer.
interface mem_byte_feeder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic              loop;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    // Host / serializer side: loads the RAM, controls playback, consumes bytes.
    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop, last_addr, dout_ready,
        input  dout, dout_valid, busy, done
    );

    // Feeder side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop, last_addr, dout_ready,
        output dout, dout_valid, busy, done
    );
endinterface

// File: rtl/mem_byte_feeder.sv
// Byte RAM with a playback engine. The host fills the RAM through the write
// port, then start plays addresses 0..last_addr in order over valid/ready,
// once or looping. Each accepted byte costs one FETCH cycle before the next
// byte is presented.
module mem_byte_feeder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    mem_byte_feeder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] last_q;
    logic              loop_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              busy_q;
    logic              done_q;

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // RAM write port; no reset so contents survive a system reset.
    always_ff @(posedge sys_clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Playback FSM with registered outputs; the FETCH read sees pre-write data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        loop_q <= bus.loop;
                        last_q <= bus.last_addr;
                        rd_ptr <= '0;
                        busy_q <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.stop) begin
                        dout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        dout_q       <= mem[rd_ptr];
                        dout_valid_q <= 1'b1;
                        state        <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.stop) begin
                        dout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end else if (dout_valid_q && bus.dout_ready) begin
                        dout_valid_q <= 1'b0;
                        if (rd_ptr != last_q) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= FETCH;
                        end else if (loop_q) begin
                            rd_ptr <= '0;
                            state  <= FETCH;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    dout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule
